fir_mac_scheduler: RTL

//  Time-multiplexed FIR controller for the ECG filter path: accepts one ECG sample
//  per valid/ready handshake and stores it in a circular delay line.

---
 rtl/fir_mac_scheduler.sv | 122 ++++++++++++
 1 files changed

// File: rtl/fir_mac_scheduler.sv
// Time-multiplexed FIR: one multiplier-accumulator walks all taps of a circular
// delay line per accepted sample, then holds the full-precision result for downstream.
`timescale 1ns/1ps
module fir_mac_scheduler #(
    parameter int  DATAWIDTH  = 16,
    parameter int  COEFFWIDTH = 32,
    parameter int  ORDER      = 41,
    localparam int ACCWIDTH   = DATAWIDTH + COEFFWIDTH + $clog2(ORDER),
    localparam int AW         = $clog2(ORDER)
) (
    input  logic                         Clk,
    input  logic                         Rst,
    input  logic                         in_valid,
    input  logic signed [DATAWIDTH-1:0]  in_data,
    output logic                         in_ready,
    output logic                         out_valid,
    output logic signed [ACCWIDTH-1:0]   out_data,
    input  logic                         out_ready,
    input  logic                         coef_we,
    input  logic        [AW-1:0]         coef_addr,
    input  logic signed [COEFFWIDTH-1:0] coef_wdata,
    output logic                         coef_err,
    output logic                         busy
);

    localparam int PW = DATAWIDTH + COEFFWIDTH;

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

    state_t                      r_state;
    state_t                      w_nextState;
    logic signed [DATAWIDTH-1:0]  r_x [ORDER];
    logic signed [COEFFWIDTH-1:0] r_h [ORDER];
    logic        [AW-1:0]         r_wrPtr;
    logic        [AW-1:0]         r_k;
    logic signed [ACCWIDTH-1:0]   r_acc;
    logic signed [ACCWIDTH-1:0]   r_outData;
    logic                         r_coefErr;

    logic                         w_accept;
    logic                         w_coefWrite;
    logic                         w_lastTap;
    logic        [AW-1:0]         w_tapIdx;
    logic signed [PW-1:0]         w_rawProd;
    logic signed [ACCWIDTH-1:0]   w_product;
    logic signed [ACCWIDTH-1:0]   w_accNext;

    assign in_ready    = (r_state == IDLE) && !Rst;
    assign out_valid   = (r_state == OUT);
    assign busy        = (r_state != IDLE);
    assign out_data    = r_outData;
    assign coef_err    = r_coefErr;

    assign w_accept    = in_valid && in_ready;
    assign w_coefWrite = coef_we && (r_state == IDLE) &&
                         ({1'b0, coef_addr} < (AW+1)'(ORDER));
    assign w_lastTap   = (r_k == AW'(ORDER - 1));

    // Tap k reads x[n-k] modulo ORDER: step back from the newest sample, wrapping.
    assign w_tapIdx    = (r_wrPtr >= r_k) ? (r_wrPtr - r_k)
                                          : (r_wrPtr + AW'(ORDER) - r_k);
    assign w_rawProd   = r_h[r_k] * r_x[w_tapIdx];
    assign w_product   = {{(ACCWIDTH-PW){w_rawProd[PW-1]}}, w_rawProd};
    assign w_accNext   = r_acc + w_product;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (w_accept)  w_nextState = MAC;
            MAC:     if (w_lastTap) w_nextState = OUT;
            OUT:     if (out_ready) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            for (int i = 0; i < ORDER; i++) begin
                r_x[i] <= '0;
                r_h[i] <= '0;
            end
            r_wrPtr   <= '0;
            r_k       <= '0;
            r_acc     <= '0;
            r_outData <= '0;
            r_coefErr <= 1'b0;
        end else begin
            r_coefErr <= coef_we && !w_coefWrite;
            if (w_coefWrite) begin
                r_h[coef_addr] <= coef_wdata;
            end
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_x[r_wrPtr] <= in_data;
                        r_acc        <= '0;
                        r_k          <= '0;
                    end
                end
                MAC: begin
                    r_acc <= w_accNext;
                    r_k   <= r_k + AW'(1);
                    // Final tap: latch the result and advance to the next sample slot.
                    if (w_lastTap) begin
                        r_outData <= w_accNext;
                        r_wrPtr   <= (r_wrPtr == AW'(ORDER - 1)) ? '0 : r_wrPtr + AW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
